// File: rtl/cmac_usplus_0_axis_pkt_chk.sv
// Receive-side AXI-Stream frame checker for the CMAC loopback test.
// Verifies frame length, keep pattern, byte ramp and MAC error flag per frame.
module cmac_usplus_0_axis_pkt_chk #(
  parameter int PKT_NUM  = 1000,
  parameter int PKT_SIZE = 522
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_restart,
  input  logic         rx_axis_tvalid,
  input  logic [511:0] rx_axis_tdata,
  input  logic [63:0]  rx_axis_tkeep,
  input  logic         rx_axis_tlast,
  input  logic         rx_axis_tuser,
  output logic [15:0]  pkt_count,
  output logic [15:0]  err_count,
  output logic         rx_busy_led,
  output logic         rx_done_led,
  output logic         rx_err_led,
  output logic [1:0]   rx_prestate
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] PKT_NUM_W  = 16'(PKT_NUM);
  localparam logic [13:0] PKT_SIZE_W = 14'(PKT_SIZE);
  localparam logic [13:0] BYTE_MAX   = 14'h3FFF;
  localparam logic [15:0] CNT_MAX    = 16'hFFFF;

  state_t      state;
  state_t      next_state;
  logic [7:0]  beat_idx;
  logic [13:0] byte_total;
  logic        frame_err;

  logic [6:0]  beat_bytes;
  logic [14:0] byte_sum;
  logic [13:0] byte_next;
  logic        keep_err;
  logic        data_err;
  logic        user_err;
  logic        len_err;
  logic        beat_err;
  logic        frame_bad;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < 64; i++) begin
      beat_bytes = beat_bytes + 7'(rx_axis_tkeep[i]);
    end
  end

  assign byte_sum  = {1'b0, byte_total} + 15'(beat_bytes);
  assign byte_next = (byte_sum > 15'(BYTE_MAX)) ? BYTE_MAX : byte_sum[13:0];

  // A last-beat keep is legal only as 2^n-1 with n>0: adding one clears every set bit.
  always_comb begin
    keep_err = 1'b0;
    if (!rx_axis_tlast) begin
      keep_err = (rx_axis_tkeep != '1);
    end else begin
      keep_err = (rx_axis_tkeep == '0) ||
                 ((rx_axis_tkeep & (rx_axis_tkeep + 64'd1)) != '0);
    end
  end

  // Expected byte (64*b + j) mod 256 is just the beat index's low two bits over j.
  always_comb begin
    data_err = 1'b0;
    for (int j = 0; j < 64; j++) begin
      if (rx_axis_tkeep[j] && (rx_axis_tdata[8*j +: 8] != {beat_idx[1:0], 6'(j)})) begin
        data_err = 1'b1;
      end
    end
  end

  assign user_err  = rx_axis_tlast && rx_axis_tuser;
  assign len_err   = rx_axis_tlast &&
                     ((byte_next != PKT_SIZE_W) || (byte_next == BYTE_MAX));
  assign beat_err  = keep_err || data_err || user_err || len_err;
  assign frame_bad = ((beat_idx != 8'd0) && frame_err) || beat_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_idx   <= '0;
      byte_total <= '0;
      frame_err  <= 1'b0;
    end else if (rx_restart) begin
      beat_idx   <= '0;
      byte_total <= '0;
      frame_err  <= 1'b0;
    end else if (rx_axis_tvalid) begin
      if (rx_axis_tlast) begin
        beat_idx   <= '0;
        byte_total <= '0;
        frame_err  <= 1'b0;
      end else begin
        beat_idx   <= (beat_idx == 8'hFF) ? beat_idx : beat_idx + 8'd1;
        byte_total <= byte_next;
        frame_err  <= frame_bad;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count  <= '0;
      err_count  <= '0;
      rx_err_led <= 1'b0;
    end else if (rx_restart) begin
      pkt_count  <= '0;
      err_count  <= '0;
      rx_err_led <= 1'b0;
    end else if (rx_axis_tvalid && rx_axis_tlast) begin
      if (pkt_count != CNT_MAX) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (frame_bad) begin
        rx_err_led <= 1'b1;
        if (err_count != CNT_MAX) begin
          err_count <= err_count + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // DONE follows the registered count, so it lands one cycle after the count update.
  always_comb begin
    next_state = state;
    if (rx_restart) begin
      next_state = IDLE;
    end else if (pkt_count >= PKT_NUM_W) begin
      next_state = DONE;
    end else begin
      case (state)
        IDLE:    if (rx_axis_tvalid && !rx_axis_tlast) next_state = RX;
        RX:      if (rx_axis_tvalid && rx_axis_tlast) next_state = IDLE;
        default: next_state = state;
      endcase
    end
  end

  assign rx_busy_led = (state == RX);
  assign rx_done_led = (state == DONE);
  assign rx_prestate = state;

endmodule

// File: tb/tb_cmac_usplus_0_axis_pkt_chk.sv
// Self-checking bench: two checker instances with different PKT_NUM/PKT_SIZE
// share one stimulus stream and are compared against a frame-level model.
module tb_cmac_usplus_0_axis_pkt_chk;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
    logic         user;
  } beat_t;

  localparam int NUM_A  = 4;
  localparam int SIZE_A = 522;
  localparam int NUM_B  = 65535;
  localparam int SIZE_B = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_restart;
  logic         rx_axis_tvalid;
  logic [511:0] rx_axis_tdata;
  logic [63:0]  rx_axis_tkeep;
  logic         rx_axis_tlast;
  logic         rx_axis_tuser;

  logic [15:0] a_pkt, a_err, b_pkt, b_err;
  logic        a_busy, a_done, a_led, b_busy, b_done, b_led;
  logic [1:0]  a_state, b_state;

  int    exp_pkt  [2];
  int    exp_err  [2];
  bit    exp_led  [2];
  bit    exp_done [2];
  int    pkt_num  [2];
  int    pkt_size [2];
  beat_t rx_q [$];
  beat_t tx_q [$];
  beat_t nil_b;
  int    checks = 0;
  int    errors = 0;

  cmac_usplus_0_axis_pkt_chk #(.PKT_NUM(NUM_A), .PKT_SIZE(SIZE_A)) dut_a (
    .clk(clk), .reset(reset), .rx_restart(rx_restart),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tdata(rx_axis_tdata),
    .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tuser(rx_axis_tuser), .pkt_count(a_pkt), .err_count(a_err),
    .rx_busy_led(a_busy), .rx_done_led(a_done), .rx_err_led(a_led),
    .rx_prestate(a_state)
  );

  cmac_usplus_0_axis_pkt_chk #(.PKT_NUM(NUM_B), .PKT_SIZE(SIZE_B)) dut_b (
    .clk(clk), .reset(reset), .rx_restart(rx_restart),
    .rx_axis_tvalid(rx_axis_tvalid), .rx_axis_tdata(rx_axis_tdata),
    .rx_axis_tkeep(rx_axis_tkeep), .rx_axis_tlast(rx_axis_tlast),
    .rx_axis_tuser(rx_axis_tuser), .pkt_count(b_pkt), .err_count(b_err),
    .rx_busy_led(b_busy), .rx_done_led(b_done), .rx_err_led(b_led),
    .rx_prestate(b_state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Whole-frame judgement: every rule applied over the stored beats at once.
  function automatic bit frameBad(input int size);
    int          total;
    int          n;
    bit          bad;
    logic [63:0] m;
    beat_t       bt;
    total = 0;
    bad   = 1'b0;
    for (int i = 0; i < rx_q.size(); i++) begin
      bt = rx_q[i];
      if (!bt.last && bt.keep != {64{1'b1}}) bad = 1'b1;
      for (int j = 0; j < 64; j++) begin
        if (bt.keep[j]) begin
          total++;
          if (bt.data[8*j +: 8] != 8'((64*i + j) % 256)) bad = 1'b1;
        end
      end
    end
    bt = rx_q[rx_q.size()-1];
    n  = $countones(bt.keep);
    m  = '0;
    for (int j = 0; j < n; j++) m[j] = 1'b1;
    if (n == 0 || bt.keep != m) bad = 1'b1;
    if (bt.user) bad = 1'b1;
    if (total != size) bad = 1'b1;
    return bad;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      exp_pkt[k]  = 0;
      exp_err[k]  = 0;
      exp_led[k]  = 1'b0;
      exp_done[k] = 1'b0;
    end
    rx_q.delete();
  endtask

  task automatic modelEdge(input logic v, input beat_t bt, input logic rs);
    bit dn [2];
    bit bad;
    if (rs) begin
      modelReset();
    end else begin
      for (int k = 0; k < 2; k++) dn[k] = exp_done[k] || (exp_pkt[k] >= pkt_num[k]);
      if (v) begin
        rx_q.push_back(bt);
        if (bt.last) begin
          for (int k = 0; k < 2; k++) begin
            bad = frameBad(pkt_size[k]);
            if (exp_pkt[k] < 65535) exp_pkt[k]++;
            if (bad) begin
              if (exp_err[k] < 65535) exp_err[k]++;
              exp_led[k] = 1'b1;
            end
          end
          rx_q.delete();
        end
      end
      for (int k = 0; k < 2; k++) exp_done[k] = dn[k];
    end
  endtask

  task automatic checkDut(input string p, input int k, input logic [15:0] pkt,
                          input logic [15:0] err, input logic busy, input logic done,
                          input logic led, input logic [1:0] st);
    int est;
    est = exp_done[k] ? 2 : ((rx_q.size() > 0) ? 1 : 0);
    checkOutput({p, "_pkt"},   32'(pkt),  32'(exp_pkt[k]));
    checkOutput({p, "_err"},   32'(err),  32'(exp_err[k]));
    checkOutput({p, "_led"},   32'(led),  32'(exp_led[k]));
    checkOutput({p, "_state"}, 32'(st),   32'(est));
    checkOutput({p, "_busy"},  32'(busy), 32'(est == 1));
    checkOutput({p, "_done"},  32'(done), 32'(est == 2));
  endtask

  task automatic checkAll();
    checkDut("a", 0, a_pkt, a_err, a_busy, a_done, a_led, a_state);
    checkDut("b", 1, b_pkt, b_err, b_busy, b_done, b_led, b_state);
  endtask

  task automatic applyStimulus(input logic v, input beat_t bt, input logic rs);
    rx_axis_tvalid = v;
    rx_axis_tdata  = bt.data;
    rx_axis_tkeep  = bt.keep;
    rx_axis_tlast  = bt.last;
    rx_axis_tuser  = bt.user;
    rx_restart     = rs;
    @(posedge clk);
    modelEdge(v, bt, rs);
    @(negedge clk);
    rx_axis_tvalid = 1'b0;
    rx_restart     = 1'b0;
  endtask

  task automatic makeFrame(input int nbytes);
    int    nb;
    int    rem;
    beat_t bt;
    tx_q.delete();
    nb = (nbytes + 63) / 64;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 64; j++) bt.data[8*j +: 8] = 8'((64*b + j) % 256);
      rem     = nbytes - 64*b;
      bt.keep = '0;
      for (int j = 0; j < 64 && j < rem; j++) bt.keep[j] = 1'b1;
      bt.last = (b == nb - 1);
      bt.user = 1'b0;
      tx_q.push_back(bt);
    end
  endtask

  // Idle cycles carry junk on every other signal to show tvalid=0 is ignored.
  task automatic sendBeats(input int gap_pct, input int restart_at);
    beat_t jb;
    for (int i = 0; i < tx_q.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        jb.data = {16{$urandom}};
        jb.keep = {$urandom, $urandom};
        jb.last = 1'($urandom_range(1));
        jb.user = 1'b1;
        applyStimulus(1'b0, jb, 1'b0);
        checkAll();
      end
      applyStimulus(1'b1, tx_q[i], i == restart_at);
      checkAll();
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    beat_t bt;
    int    sel, nbytes, flt, bi, bj, rs_at;
    pkt_num[0]  = NUM_A;  pkt_num[1]  = NUM_B;
    pkt_size[0] = SIZE_A; pkt_size[1] = SIZE_B;
    nil_b.data = '0; nil_b.keep = '0; nil_b.last = 1'b0; nil_b.user = 1'b0;
    reset = 1'b1; rx_restart = 1'b0; rx_axis_tvalid = 1'b0;
    rx_axis_tdata = '0; rx_axis_tkeep = '0; rx_axis_tlast = 1'b0; rx_axis_tuser = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkAll();
    reset = 1'b0;

    $display("[TB] four good 522-byte frames");
    for (int f = 0; f < 4; f++) begin
      makeFrame(522);
      sendBeats(0, -1);
    end
    checkOutput("good_pkt", 32'(a_pkt), 32'd4);
    checkOutput("good_err", 32'(a_err), 32'd0);
    checkOutput("good_done_early", 32'(a_done), 32'd0);
    applyStimulus(1'b0, nil_b, 1'b0);
    checkAll();
    checkOutput("good_done", 32'(a_done), 32'd1);
    checkOutput("good_led", 32'(a_led), 32'd0);

    $display("[TB] corrupted data and tuser");
    applyStimulus(1'b0, nil_b, 1'b1);
    checkAll();
    for (int f = 0; f < 4; f++) begin
      makeFrame(522);
      if (f == 1) begin
        bt = tx_q[2];
        bt.data[8*5 +: 8] = bt.data[8*5 +: 8] ^ 8'hFF;
        tx_q[2] = bt;
      end
      if (f == 3) begin
        bt = tx_q[tx_q.size()-1];
        bt.user = 1'b1;
        tx_q[tx_q.size()-1] = bt;
      end
      sendBeats(0, -1);
      if (f == 0) checkOutput("corrupt_led_before", 32'(a_led), 32'd0);
      if (f == 1) checkOutput("corrupt_led", 32'(a_led), 32'd1);
    end
    checkOutput("corrupt_err", 32'(a_err), 32'd2);
    checkOutput("corrupt_pkt", 32'(a_pkt), 32'd4);

    $display("[TB] length and keep errors");
    applyStimulus(1'b0, nil_b, 1'b1);
    makeFrame(521);
    sendBeats(0, -1);
    checkOutput("len521_err", 32'(a_err), 32'd1);
    makeFrame(522);
    bt = tx_q[0]; bt.keep = 64'h7FFF_FFFF_FFFF_FFFF; tx_q[0] = bt;
    sendBeats(0, -1);
    checkOutput("keep_mid_err", 32'(a_err), 32'd2);
    makeFrame(522);
    bt = tx_q[8]; bt.keep = 64'h0F0; tx_q[8] = bt;
    sendBeats(0, -1);
    checkOutput("keep_last_err", 32'(a_err), 32'd3);
    checkOutput("keep_last_pkt", 32'(a_pkt), 32'd3);

    $display("[TB] single-beat frames and gaps");
    applyStimulus(1'b0, nil_b, 1'b1);
    makeFrame(64);
    sendBeats(0, -1);
    checkOutput("single_state", 32'(b_state), 32'd0);
    checkOutput("single_pkt", 32'(b_pkt), 32'd1);
    checkOutput("single_err", 32'(b_err), 32'd0);
    makeFrame(522);
    sendBeats(40, -1);
    makeFrame(64);
    sendBeats(0, -1);
    checkOutput("gap_b_pkt", 32'(b_pkt), 32'd3);
    checkOutput("gap_b_err", 32'(b_err), 32'd1);
    checkOutput("gap_a_err", 32'(a_err), 32'd2);

    $display("[TB] restart mid-frame");
    makeFrame(522);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, tx_q[i], 1'b0);
      checkAll();
    end
    checkOutput("pre_restart_busy", 32'(a_busy), 32'd1);
    applyStimulus(1'b1, tx_q[3], 1'b1);
    checkAll();
    checkOutput("restart_pkt", 32'(a_pkt), 32'd0);
    checkOutput("restart_state", 32'(a_state), 32'd0);
    for (int i = 4; i < 9; i++) begin
      applyStimulus(1'b1, tx_q[i], 1'b0);
      checkAll();
    end
    checkOutput("tail_pkt", 32'(a_pkt), 32'd1);
    checkOutput("tail_err", 32'(a_err), 32'd1);

    $display("[TB] async reset mid-frame");
    makeFrame(522);
    sendBeats(0, -1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, tx_q[i], 1'b0);
      checkAll();
    end
    #2 reset = 1'b1;
    #1;
    checkOutput("areset_pkt", 32'(a_pkt), 32'd0);
    checkOutput("areset_err", 32'(a_err), 32'd0);
    checkOutput("areset_led", 32'(a_led), 32'd0);
    checkOutput("areset_state", 32'(a_state), 32'd0);
    checkOutput("areset_busy", 32'(a_busy), 32'd0);
    checkOutput("areset_b_pkt", 32'(b_pkt), 32'd0);
    modelReset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkAll();
    makeFrame(522);
    sendBeats(0, -1);
    checkOutput("post_reset_pkt", 32'(a_pkt), 32'd1);
    checkOutput("post_reset_err", 32'(a_err), 32'd0);

    $display("[TB] randomized frames");
    applyStimulus(1'b0, nil_b, 1'b1);
    checkAll();
    for (int f = 0; f < 150; f++) begin
      sel    = int'($urandom_range(9));
      nbytes = (sel < 4) ? 522 : ((sel < 7) ? 64 : int'($urandom_range(700, 1)));
      makeFrame(nbytes);
      flt = int'($urandom_range(7));
      if (flt == 1) begin
        bi = int'($urandom_range(tx_q.size() - 1));
        bt = tx_q[bi];
        bj = int'($urandom_range($countones(bt.keep) - 1));
        bt.data[8*bj +: 8] = bt.data[8*bj +: 8] ^ 8'($urandom_range(255, 1));
        tx_q[bi] = bt;
      end else if (flt == 2) begin
        bt = tx_q[tx_q.size()-1]; bt.user = 1'b1; tx_q[tx_q.size()-1] = bt;
      end else if (flt == 3 && tx_q.size() > 1) begin
        bi = int'($urandom_range(tx_q.size() - 2));
        bt = tx_q[bi]; bt.keep = bt.keep & {$urandom, $urandom}; tx_q[bi] = bt;
      end else if (flt == 4) begin
        bt = tx_q[tx_q.size()-1];
        bt.keep = bt.keep << $urandom_range(3, 1);
        tx_q[tx_q.size()-1] = bt;
      end
      rs_at = ($urandom_range(14) == 0) ? int'($urandom_range(tx_q.size() - 1)) : -1;
      sendBeats(int'($urandom_range(30)), rs_at);
    end

    $display("[TB] counter saturation");
    applyStimulus(1'b0, nil_b, 1'b1);
    checkAll();
    makeFrame(64);
    bt = tx_q[0];
    bt.user = 1'b1;
    for (int i = 0; i < 65537; i++) applyStimulus(1'b1, bt, 1'b0);
    applyStimulus(1'b0, nil_b, 1'b0);
    checkAll();
    checkOutput("sat_a_pkt", 32'(a_pkt), 32'h0000_FFFF);
    checkOutput("sat_a_err", 32'(a_err), 32'h0000_FFFF);
    checkOutput("sat_b_pkt", 32'(b_pkt), 32'h0000_FFFF);
    checkOutput("sat_b_err", 32'(b_err), 32'h0000_FFFF);
    checkOutput("sat_b_done", 32'(b_done), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmac_usplus_0_axis_pkt_chk.md
CMAC_USPLUS_0_AXIS_PKT_CHK -- requirements
Module: cmac_usplus_0_axis_pkt_chk

Interface
REQ-001 SHALL have parameter PKT_NUM, default 1000, number of packets expected per test run (1..65535).
REQ-002 SHALL have parameter PKT_SIZE, default 522, expected frame length in bytes (64..16000).
REQ-003 SHALL have port clk, input, 1, RX user clock; all logic is on this one clock.
REQ-004 SHALL have port reset, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port rx_restart, input, 1, synchronous pulse that clears all counters and status and re-arms the check.
REQ-006 SHALL have port rx_axis_tvalid, input, 1, beat valid; there is no tready, and every valid beat is consumed.
REQ-007 SHALL have port rx_axis_tdata, input, 512, beat data; byte j is tdata[8j+7:8j].
REQ-008 SHALL have port rx_axis_tkeep, input, 64, byte enables.
REQ-009 SHALL have port rx_axis_tlast, input, 1, last beat of a frame.
REQ-010 SHALL have port rx_axis_tuser, input, 1, MAC error flag; it is sampled only on the tlast beat.
REQ-011 SHALL have port pkt_count, output, 16, frames received.
REQ-012 SHALL have port err_count, output, 16, frames that contain one or more errors.
REQ-013 SHALL have port rx_busy_led, output, 1, high while the state is RX.
REQ-014 SHALL have port rx_done_led, output, 1, high when the state is DONE.
REQ-015 SHALL have port rx_err_led, output, 1, sticky flag meaning at least one bad frame has been received.
REQ-016 SHALL have port rx_prestate, output, 2, current state encoding for the ILA.

Function
REQ-017 SHALL implement the states IDLE=0, RX=1 and DONE=2.
REQ-018 SHALL use the following transitions:
- IDLE->RX on a valid beat with tlast=0.
- IDLE stays IDLE on a single-beat frame (valid & tlast).
- RX->IDLE on a valid beat with tlast=1.
- Any state->DONE in the cycle after the frame that makes pkt_count reach PKT_NUM.
- DONE->IDLE only on rx_restart.
REQ-019 SHALL count, per frame, the beat index b (0-based) and the byte total, where the byte total is the running sum of popcount(tkeep).
REQ-020 SHALL check each frame for the following error conditions:
- (a) On a non-last beat, tkeep is not all-ones.
- (b) On the last beat, tkeep is not of the form contiguous-ones-from-bit-0, or it is zero.
- (c) Any kept byte j of beat b is not equal to (64*b+j) mod 256.
- (d) tuser=1 on the last beat.
- (e) The frame byte total is not equal to PKT_SIZE.
REQ-021 SHALL register the error conditions into a per-frame error flag that is cleared at the start of each frame.
REQ-022 SHALL update pkt_count, and err_count when the frame is bad, exactly 1 cycle after the tlast beat.
REQ-023 SHALL set rx_err_led in the same cycle as err_count increments.
REQ-024 SHALL saturate pkt_count and err_count at 16'hFFFF with no wrap-around.
REQ-025 SHALL saturate the beat index at 255 and the byte total at 16383; a saturated byte total forces error (e).
REQ-026 SHALL keep checking and counting frames while in DONE; the state stays DONE.
REQ-027 SHALL ignore beats when tvalid=0, and the checker state SHALL hold.
REQ-028 SHALL give rx_restart priority over a beat in the same cycle:
- Counters, flags and LEDs clear.
- The state goes to IDLE.
- That beat is discarded.
REQ-029 SHALL give a frame that is in progress at rx_restart no credit; its remaining beats are treated as a new frame starting at beat index 0.

Reset
REQ-030 SHALL force the following on assertion of reset, asynchronously:
- State to IDLE.
- pkt_count=0 and err_count=0.
- Beat index and byte total to 0.
- All LEDs to 0.
- rx_prestate=0.
REQ-031 SHALL start checking on the first clk edge after reset deasserts, with no warm-up cycles.
REQ-032 SHALL discard a frame that is in progress when reset asserts, with no count.

Verification
REQ-033 Good frames: PKT_NUM=4, PKT_SIZE=522, send 4 correct 9-beat frames (last tkeep=64'h3FF) -> pkt_count=4, err_count=0, rx_done_led=1 in the cycle after the 4th frame's tlast+1, rx_err_led=0.
REQ-034 Corrupted data and tuser: corrupt byte 5 of beat 2 in frame 1 and set tuser on frame 3 -> err_count=2, rx_err_led=1 from the cycle after frame 1 ends, pkt_count=4.
REQ-035 Length and keep errors:
- A 521-byte frame -> err_count increments.
- A non-last beat with tkeep=64'h7FFF_FFFF_FFFF_FFFF -> err_count increments.
- A last beat with tkeep=64'h0F0 -> err_count increments.
REQ-036 Single-beat frame: PKT_SIZE=64, send one beat with valid & tlast and full tkeep -> state stays IDLE, pkt_count=1 next cycle; with gaps of tvalid=0 inserted mid-frame in other frames, the result is the same.
REQ-037 Restart and reset mid-frame:
- Assert rx_restart together with beat 3 of a frame -> counters are 0 and the state is IDLE next cycle.
- Assert async reset between clk edges -> outputs are 0 immediately.
REQ-038 Counter saturation: with PKT_NUM=65535, send 65537 bad frames -> pkt_count=err_count=16'hFFFF, rx_done_led=1.
